// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers and a busy counter.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) enabled by `define MDU_MADD_EN.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    logic [0:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_hi, w_hi_nxt;
    logic [31:0]      r_lo, w_lo_nxt;
    logic [31:0]      r_hi_p, w_hi_p_nxt;
    logic [31:0]      r_lo_p, w_lo_p_nxt;
    logic             r_commit, w_commit_nxt;

    // Full 64-bit products; low 64 bits of the sign-extended product equal the signed product
    logic [63:0] w_prod_s, w_prod_u;
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN with zero remainder
    logic        w_div_signed, w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_quot, w_rem;
    assign w_div_signed = (MDOp == OP_DIV);
    assign w_a_neg      = w_div_signed & A[31];
    assign w_b_neg      = w_div_signed & B[31];
    assign w_a_mag      = w_a_neg ? (~A + 32'd1) : A;
    assign w_b_mag      = w_b_neg ? (~B + 32'd1) : B;
    assign w_b_safe     = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_safe;
    assign w_r_mag      = w_a_mag % w_b_safe;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

`ifdef MDU_MADD_EN
    // Accumulate against HI/LO as sampled at the Start edge
    logic [63:0] w_prod_sel, w_acc, w_madd;
    assign w_prod_sel = (MDOp == OP_MADD || MDOp == OP_MSUB) ? w_prod_s : w_prod_u;
    assign w_acc      = {r_hi, r_lo};
    assign w_madd     = (MDOp == OP_MSUB || MDOp == OP_MSUBU) ? (w_acc - w_prod_sel)
                                                              : (w_acc + w_prod_sel);
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_hi_p_nxt   = r_hi_p;
        w_lo_p_nxt   = r_lo_p;
        w_commit_nxt = r_commit;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    case (MDOp)
                        OP_MULT: begin
                            w_state_nxt              = S_RUN;
                            w_cnt_nxt                = CNT_W'(MULT_CYCLES);
                            {w_hi_p_nxt, w_lo_p_nxt} = w_prod_s;
                            w_commit_nxt             = 1'b1;
                        end
                        OP_MULTU: begin
                            w_state_nxt              = S_RUN;
                            w_cnt_nxt                = CNT_W'(MULT_CYCLES);
                            {w_hi_p_nxt, w_lo_p_nxt} = w_prod_u;
                            w_commit_nxt             = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_state_nxt  = S_RUN;
                            w_cnt_nxt    = CNT_W'(DIV_CYCLES);
                            w_hi_p_nxt   = w_rem;
                            w_lo_p_nxt   = w_quot;
                            w_commit_nxt = (B != 32'd0);
                        end
                        OP_MTHI: w_hi_nxt = A;
                        OP_MTLO: w_lo_nxt = A;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            w_state_nxt              = S_RUN;
                            w_cnt_nxt                = CNT_W'(MULT_CYCLES);
                            {w_hi_p_nxt, w_lo_p_nxt} = w_madd;
                            w_commit_nxt             = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    if (r_commit) begin
                        w_hi_nxt = r_hi_p;
                        w_lo_nxt = r_lo_p;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_hi_p   <= '0;
            r_lo_p   <= '0;
            r_commit <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_hi_p   <= w_hi_p_nxt;
            r_lo_p   <= w_lo_p_nxt;
            r_commit <= w_commit_nxt;
        end
    end

    assign Busy = (r_state == S_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences, random ops vs. model.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        CLK;
    logic        RESET;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } vec_t;

    vec_t tbl[16];
    int   nvec = 0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MDOp(MDOp),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo, input int lat,
                           input string name);
        tbl[nvec] = '{op, a, b, hi, lo, lat, name};
        nvec++;
    endtask

    // Reference behaviour from the architectural rules
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo,
                          output logic [31:0] nhi, output logic [31:0] nlo, output int lat);
        longint      ps;
        logic [63:0] pu;
        int          sa, sb;
        nhi = hi;
        nlo = lo;
        lat = 0;
        case (op)
            4'd1: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                {nhi, nlo} = ps;
                lat = MC;
            end
            4'd2: begin
                pu = {32'd0, a} * {32'd0, b};
                {nhi, nlo} = pu;
                lat = MC;
            end
            4'd3: begin
                lat = DC;
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        nlo = 32'h8000_0000;
                        nhi = 32'd0;
                    end else begin
                        sa = $signed(a);
                        sb = $signed(b);
                        nlo = sa / sb;
                        nhi = sa % sb;
                    end
                end
            end
            4'd4: begin
                lat = DC;
                if (b != 0) begin
                    nlo = a / b;
                    nhi = a % b;
                end
            end
            4'd5: nhi = a;
            4'd6: nlo = a;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: begin
                if (op == 4'd7 || op == 4'd9)
                    pu = 64'(longint'($signed(a)) * longint'($signed(b)));
                else
                    pu = {32'd0, a} * {32'd0, b};
                if (op == 4'd7 || op == 4'd8) {nhi, nlo} = {hi, lo} + pu;
                else                          {nhi, nlo} = {hi, lo} - pu;
                lat = MC;
            end
`endif
            default: ;
        endcase
    endtask

    // Issue one op from idle, count busy cycles, check hold during busy and final HI/LO
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int elat,
                          input string nm);
        int n;
        logic hold_ok;
        @(negedge CLK);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        MDOp  = 4'd0;
        A     = $urandom;
        B     = $urandom;
        n = 0;
        hold_ok = 1'b1;
        while (Busy === 1'b1 && n < 200) begin
            n++;
            if (HI !== m_hi || LO !== m_lo) hold_ok = 1'b0;
            @(posedge CLK);
            #1;
        end
        chk({nm, "_busy_cycles"}, 32'(n), 32'(elat));
        chk({nm, "_hold"}, {31'd0, hold_ok}, 32'd1);
        chk({nm, "_hi"}, HI, ehi);
        chk({nm, "_lo"}, LO, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb, rhi, rlo;
        int          rlat, n;

        RESET = 1'b0;
        Start = 1'b0;
        MDOp  = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;

        #12;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        add_vec(4'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MC, "mult_neg1x2");
        add_vec(4'd2, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, MC, "multu_x2");
        add_vec(4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC, "div_m7_2");
        add_vec(4'd5, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFD, 0,  "mthi");
        add_vec(4'd6, 32'h0000_5678, 32'd0,         32'h0000_1234, 32'h0000_5678, 0,  "mtlo");
        add_vec(4'd4, 32'd7,         32'd0,         32'h0000_1234, 32'h0000_5678, DC, "divu_by0");
        add_vec(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC, "div_ovf");
        add_vec(4'd4, 32'd100,       32'd7,         32'd2,         32'd14,        DC, "divu_100_7");
        add_vec(4'd0, 32'd55,        32'd66,        32'd2,         32'd14,        0,  "op_none");
        add_vec(4'd15, 32'd55,       32'd66,        32'd2,         32'd14,        0,  "op_undef");
        add_vec(4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DC, "div_7_m2");
        add_vec(4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         DC, "div_m7_m2");
        add_vec(4'd5, 32'd0,         32'd0,         32'd0,         32'd3,         0,  "mthi_0");
        add_vec(4'd6, 32'hFFFF_FFFF, 32'd0,         32'd0,         32'hFFFF_FFFF, 0,  "mtlo_ones");
`ifdef MDU_MADD_EN
        add_vec(4'd8, 32'd1,         32'd1,         32'd1,         32'd0,         MC, "maddu_carry");
`else
        add_vec(4'd8, 32'd1,         32'd1,         32'd0,         32'hFFFF_FFFF, 0,  "maddu_off");
`endif

        for (int i = 0; i < nvec; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].lat, tbl[i].name);

        // A MULT started while a DIVU is in flight must be ignored
        @(negedge CLK);
        Start = 1'b1;
        MDOp  = 4'd4;
        A     = 32'd100;
        B     = 32'd7;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 200) begin
            n++;
            Start = (n == 3);
            MDOp  = 4'd1;
            A     = 32'd3;
            B     = 32'd3;
            @(posedge CLK);
            #1;
        end
        Start = 1'b0;
        MDOp  = 4'd0;
        chk("busy_guard_cycles", 32'(n), 32'(DC));
        chk("busy_guard_hi", HI, 32'd2);
        chk("busy_guard_lo", LO, 32'd14);
        @(posedge CLK);
        #1;
        chk("busy_guard_no_restart", {31'd0, Busy}, 32'd0);
        m_hi = 32'd2;
        m_lo = 32'd14;

        // Asynchronous reset mid-MULT aborts it
        @(negedge CLK);
        Start = 1'b1;
        MDOp  = 4'd1;
        A     = 32'd5;
        B     = 32'd7;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        MDOp  = 4'd0;
        @(posedge CLK);
        #1;
        chk("pre_reset_busy", {31'd0, Busy}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, Busy}, 32'd0);
        chk("async_reset_hi", HI, 32'd0);
        chk("async_reset_lo", LO, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (MC + 3) @(posedge CLK);
        #1;
        chk("post_reset_busy", {31'd0, Busy}, 32'd0);
        chk("post_reset_hi", HI, 32'd0);
        chk("post_reset_lo", LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        // Random ops against the reference model
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 9) == 0) rop = 4'd15;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 16));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            ref_op(rop, ra, rb, m_hi, m_lo, rhi, rlo, rlat);
            run_op(rop, ra, rb, rhi, rlo, rlat, $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
